ddr3_inport_ram_responder: RTL

// - Synthesizable responder for the 128-bit inport request/response interface that ddr3_core exposes.
// - Block-RAM backed; drop-in stand-in for ddr3_core + PHY + DRAM when bringing up or simulating initiators (CPU/cache/DMA).
// - Has the same accept/ack/resp_id semantics as ddr3_core, plus configurable latency, outstanding limit and accept throttling.

---
 rtl/ddr3_inport_ram_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ddr3_inport_ram_responder.sv
// Block-RAM stand-in for the ddr3_core 128-bit inport: in-order responses after a fixed latency.
// Optional macro DDR3_INPORT_RAM_RANGE_CHECK_EN: out-of-range addresses are acked with error=1.
module ddr3_inport_ram_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int RESP_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_PERIOD    = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [15:0]  inport_wr_i,
    input  logic         inport_rd_i,
    input  logic [31:0]  inport_addr_i,
    input  logic [127:0] inport_write_data_i,
    input  logic [15:0]  inport_req_id_i,
    output logic         inport_accept_o,
    output logic         inport_ack_o,
    output logic         inport_error_o,
    output logic [15:0]  inport_resp_id_o,
    output logic [127:0] inport_read_data_o
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int LAST   = RESP_LATENCY - 1;

    logic [127:0]      mem_q [DEPTH_WORDS];

    logic [3:0]        outstanding_q, outstanding_d;
    logic              valid_q [RESP_LATENCY];
    logic              valid_d [RESP_LATENCY];
    logic [15:0]       id_q    [RESP_LATENCY];
    logic [15:0]       id_d    [RESP_LATENCY];
    logic              err_q   [RESP_LATENCY];
    logic              err_d   [RESP_LATENCY];
    logic [127:0]      rdata_q [RESP_LATENCY];
    logic [127:0]      rdata_d [RESP_LATENCY];

    logic              is_write_s;
    logic              is_req_s;
    logic              take_s;
    logic              ack_s;
    logic              accept_s;
    logic              stall_slot_s;
    logic              oor_s;
    logic [ADDR_W-1:0] word_s;
    logic [127:0]      s0_rdata_s;
    logic              unused_s;

    assign unused_s = ^{inport_addr_i[3:0], inport_addr_i[31:ADDR_W+4]};

`ifdef DDR3_INPORT_RAM_RANGE_CHECK_EN
    assign oor_s = |inport_addr_i[31:ADDR_W+4];
`else
    assign oor_s = 1'b0;
`endif

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            logic [SW-1:0] stall_cnt_q, stall_cnt_d;

            assign stall_slot_s = (stall_cnt_q == SW'(STALL_PERIOD - 1));

            always_comb begin
                if (stall_slot_s) begin
                    stall_cnt_d = {SW{1'b0}};
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stall_cnt_q <= {SW{1'b0}};
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                end
            end
        end else begin : g_no_stall
            assign stall_slot_s = 1'b0;
        end
    endgenerate

    // Accept depends only on internal state so initiators may hold requests against it.
    assign accept_s        = ~rst_i & (outstanding_q < 4'(MAX_OUTSTANDING)) & ~stall_slot_s;
    assign inport_accept_o = accept_s;

    assign is_write_s = (inport_wr_i != 16'h0000);
    assign is_req_s   = is_write_s | inport_rd_i;
    assign take_s     = accept_s & is_req_s;
    assign word_s     = inport_addr_i[ADDR_W+3:4];
    assign ack_s      = valid_q[LAST];
    assign s0_rdata_s = (take_s & ~is_write_s & ~oor_s) ? mem_q[word_s] : 128'h0;

    always_comb begin
        valid_d[0] = take_s;
        id_d[0]    = take_s ? inport_req_id_i : 16'h0000;
        err_d[0]   = take_s & oor_s;
        rdata_d[0] = take_s ? s0_rdata_s : rdata_q[0];
        for (int i = 1; i < RESP_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = valid_q[i-1] ? rdata_q[i-1] : rdata_q[i];
        end
    end

    always_comb begin
        case ({take_s, ack_s})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Reset drops everything in flight; read data resets to zero and otherwise holds between acks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= 4'd0;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= 16'h0000;
                err_q[i]   <= 1'b0;
                rdata_q[i] <= 128'h0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                valid_q[i] <= valid_d[i];
                id_q[i]    <= id_d[i];
                err_q[i]   <= err_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Byte-masked RAM write; contents are intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (take_s & is_write_s & ~oor_s) begin
            for (int b = 0; b < 16; b++) begin
                if (inport_wr_i[b]) begin
                    mem_q[word_s][8*b +: 8] <= inport_write_data_i[8*b +: 8];
                end
            end
        end
    end

    assign inport_ack_o       = valid_q[LAST];
    assign inport_error_o     = err_q[LAST];
    assign inport_resp_id_o   = id_q[LAST];
    assign inport_read_data_o = rdata_q[LAST];

endmodule
